// File: rtl/asic_clkdiv_prog_pkg.sv
// Shared types and helpers for the programmable clock divider.
// Used by the top module and by its counter.
package asic_clkdiv_prog_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

  localparam int RATIO_MIN = 2;

  // Length of the high phase for ratio r: the odd cycle goes to the high phase.
  function automatic logic [31:0] hi_of(input logic [31:0] r);
    return r - (r >> 1);
  endfunction

endpackage

// File: rtl/asic_clkdiv_cnt.sv
// N-bit wrap counter: counts 0..ratio-1, raises tc on the last count, and accepts a load.
// Exposes cnt_next so that the parent can register decodes of the following count.
module asic_clkdiv_cnt
  import asic_clkdiv_prog_pkg::*;
#(
  parameter int    N    = 8,
  parameter string PROP = "DEFAULT"
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic         step,
  input  logic         load,
  input  logic [N-1:0] load_val,
  input  logic [N-1:0] ratio,
  output logic [N-1:0] cnt_next,
  output logic         tc
);

  logic [N-1:0] cnt;

  // PROP picks the terminal-count compare structure. Both forms agree because cnt < ratio.
  localparam bit TC_INC = (PROP == "SPEED");

  if (TC_INC) begin : g_tc_inc
    assign tc = ((cnt + N'(1)) == ratio);
  end else begin : g_tc_dec
    assign tc = (cnt == (ratio - N'(1)));
  end

  always_comb begin
    cnt_next = cnt;
    if (load) begin
      cnt_next = load_val;
    end else if (step) begin
      cnt_next = tc ? '0 : cnt + N'(1);
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_next;
    end
  end

endmodule

// File: rtl/asic_clkdiv_prog.sv
// Programmable integer clock divider with glitch-free ratio changes at period boundaries.
// clkout is a plain register output so that the downstream inverter sees a clean clock.
module asic_clkdiv_prog
  import asic_clkdiv_prog_pkg::*;
#(
  parameter int    N    = 8,
  parameter string PROP = "DEFAULT"
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic         en,
  input  logic         cfg_valid,
  input  logic [N-1:0] cfg_div,
  output logic         cfg_ready,
  output logic         clkout,
  output logic         rise,
  output logic         fall,
  output logic         active
);

  state_t       state, state_next;
  logic [N-1:0] ratio, ratio_next;
  logic [N-1:0] pend, pend_next;
  logic         pend_valid, pend_valid_next;
  logic [N-1:0] cfg_clamped;
  logic [N-1:0] cnt_next, cnt_load_val, hi_next;
  logic         xfer, tc, cnt_load, cnt_step, force_low, clkout_next;

  // Config handshake: a ratio moves when cfg_valid && cfg_ready at a clk edge; the offerer
  // holds cfg_valid and cfg_div steady until then. One pending slot, so ready = slot empty.
  assign cfg_ready   = !pend_valid;
  assign xfer        = cfg_valid && cfg_ready;
  assign cfg_clamped = (cfg_div < N'(RATIO_MIN)) ? N'(RATIO_MIN) : cfg_div;

  always_comb begin
    state_next      = state;
    ratio_next      = ratio;
    pend_next       = pend;
    pend_valid_next = pend_valid;
    cnt_load        = 1'b0;
    cnt_load_val    = '0;
    cnt_step        = 1'b0;
    force_low       = 1'b0;
    case (state)
      IDLE: begin
        force_low = 1'b1;
        if (xfer) ratio_next = cfg_clamped;
        // Park the counter on the boundary so the next edge opens a full period.
        if (en) begin
          state_next   = RUN;
          cnt_load     = 1'b1;
          cnt_load_val = ratio_next - N'(1);
        end
      end
      RUN, STOP: begin
        cnt_step = 1'b1;
        if (tc && pend_valid) begin
          ratio_next      = pend;
          pend_valid_next = 1'b0;
        end
        if (xfer) begin
          pend_next       = cfg_clamped;
          pend_valid_next = 1'b1;
        end
        if (en) begin
          state_next = RUN;
        end else if (state == STOP && tc) begin
          state_next = IDLE;
          force_low  = 1'b1;
        end else begin
          state_next = STOP;
        end
      end
      default: begin
        state_next = IDLE;
        force_low  = 1'b1;
      end
    endcase
  end

  // High phase of the period that cnt_next belongs to, which may use a just-applied ratio.
  assign hi_next     = N'(hi_of(32'(ratio_next)));
  assign clkout_next = !force_low && (cnt_next < hi_next);

  asic_clkdiv_cnt #(
    .N    (N),
    .PROP (PROP)
  ) u_cnt (
    .clk      (clk),
    .nreset   (nreset),
    .step     (cnt_step),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .ratio    (ratio),
    .cnt_next (cnt_next),
    .tc       (tc)
  );

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state      <= IDLE;
      ratio      <= N'(RATIO_MIN);
      pend       <= '0;
      pend_valid <= 1'b0;
      clkout     <= 1'b0;
      rise       <= 1'b0;
      fall       <= 1'b0;
      active     <= 1'b0;
    end else begin
      state      <= state_next;
      ratio      <= ratio_next;
      pend       <= pend_next;
      pend_valid <= pend_valid_next;
      clkout     <= clkout_next;
      rise       <= clkout_next && !clkout;
      fall       <= !clkout_next && clkout;
      active     <= (state_next != IDLE);
    end
  end

endmodule

// File: tb/tb_asic_clkdiv_prog.sv
// Self-checking bench for asic_clkdiv_prog: waveform tables, hand-written corner sequences
// and randomized ratio/enable traffic against a bit-stream reference model.
module tb_asic_clkdiv_prog;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         nreset = 1'b0;
  logic         en = 1'b0;
  logic         cfg_valid = 1'b0;
  logic [N-1:0] cfg_div = '0;
  logic         cfg_ready, clkout, rise, fall, active;

  asic_clkdiv_prog #(.N(N), .PROP("DEFAULT")) dut (
    .clk       (clk),
    .nreset    (nreset),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_div   (cfg_div),
    .cfg_ready (cfg_ready),
    .clkout    (clkout),
    .rise      (rise),
    .fall      (fall),
    .active    (active)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // The expected clkout stream is a queue of bits: each new period pushes ceil(R/2) ones
  // followed by floor(R/2) zeros, and every clk edge pops one bit.
  logic [0:0] exp_q[$];
  int  m_cur, m_pend;
  bit  m_pend_have, m_run, m_stopping, m_out, m_prev, m_rise, m_fall, m_took;

  function automatic int clamp_ratio(input logic [N-1:0] d);
    return (int'(d) < 2) ? 2 : int'(d);
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_cur = 2; m_pend = 0; m_pend_have = 0;
    m_run = 0; m_stopping = 0; m_out = 0; m_prev = 0; m_rise = 0; m_fall = 0; m_took = 0;
  endtask

  task automatic model_edge(input logic e, input logic x, input logic [N-1:0] d);
    if (!m_run) begin
      if (x) m_cur = clamp_ratio(d);
      if (e) begin
        m_run = 1; m_stopping = 0;
      end
      m_out = 0;
    end else begin
      if (exp_q.size() == 0) begin
        if (m_pend_have) begin
          m_cur = m_pend; m_pend_have = 0;
        end
        if (m_stopping && !e) m_run = 0;
        else for (int i = 0; i < m_cur; i++) exp_q.push_back(1'(i < (m_cur + 1) / 2));
      end
      m_out = m_run ? exp_q.pop_front() : 1'b0;
      if (x) begin
        m_pend = clamp_ratio(d); m_pend_have = 1;
      end
      m_stopping = m_run && !e;
    end
    m_rise = m_out && !m_prev;
    m_fall = !m_out && m_prev;
    m_prev = m_out;
  endtask

  // ---------------- driver tasks ----------------
  // One clk edge: inputs are sampled by model and DUT at the posedge, outputs checked at negedge.
  task automatic tick();
    logic x;
    x = cfg_valid && !m_pend_have;
    m_took = x;
    @(posedge clk);
    model_edge(en, x, cfg_div);
    @(negedge clk);
    if (x) cfg_valid = 1'b0;
    chk("clkout", clkout, m_out);
    chk("rise", rise, m_rise);
    chk("fall", fall, m_fall);
    chk("active", active, m_run);
    chk("cfg_ready", cfg_ready, !m_pend_have);
  endtask

  task automatic do_reset();
    nreset = 1'b0; en = 1'b0; cfg_valid = 1'b0; cfg_div = '0;
    repeat (2) @(negedge clk);
    nreset = 1'b1;
    model_reset();
    chk("rst_clkout", clkout, 0);
    chk("rst_rise", rise, 0);
    chk("rst_fall", fall, 0);
    chk("rst_active", active, 0);
    chk("rst_cfg_ready", cfg_ready, 1);
  endtask

  task automatic program_idle(input logic [N-1:0] d);
    cfg_div = d; cfg_valid = 1'b1;
    tick();
  endtask

  task automatic start_run();
    en = 1'b1;
    tick();
    tick();
  endtask

  task automatic wait_rise();
    int k;
    k = 0;
    while (!(clkout === 1'b1 && rise === 1'b1) && k < 600) begin
      tick(); k++;
    end
    chk("wait_rise_in_bound", (k < 600), 1);
  endtask

  // Call right after a rise; returns high/low run lengths and ends on the next rise.
  task automatic measure(output int hi, output int lo);
    hi = 0; lo = 0;
    while (clkout === 1'b1 && hi < 600) begin
      hi++; tick();
    end
    while (clkout === 1'b0 && lo < 600) begin
      lo++; tick();
    end
  endtask

  typedef struct {
    logic [N-1:0] div;
    int           hi;
    int           lo;
  } vec_t;

  initial begin
    vec_t vecs[9];
    int   h, l, k;

    vecs[0] = '{8'd0,   1,   1};
    vecs[1] = '{8'd1,   1,   1};
    vecs[2] = '{8'd2,   1,   1};
    vecs[3] = '{8'd3,   2,   1};
    vecs[4] = '{8'd5,   3,   2};
    vecs[5] = '{8'd6,   3,   3};
    vecs[6] = '{8'd7,   4,   3};
    vecs[7] = '{8'd16,  8,   8};
    vecs[8] = '{8'd255, 128, 127};

    @(negedge clk);

    // Table: ratio loaded in IDLE, first rise two edges after en, then three periods.
    for (int v = 0; v < 9; v++) begin
      do_reset();
      program_idle(vecs[v].div);
      en = 1'b1;
      tick();
      chk("latency_edge1_low", clkout, 0);
      tick();
      chk("latency_edge2_rise", {clkout, rise}, 2'b11);
      for (int p = 0; p < 3; p++) begin
        measure(h, l);
        chk("table_hi", h, vecs[v].hi);
        chk("table_lo", l, vecs[v].lo);
      end
    end

    // Ratio change mid-period, plus a second offer while the slot is full.
    do_reset();
    program_idle(8'd4);
    start_run();
    tick();
    cfg_div = 8'd7; cfg_valid = 1'b1;
    tick();
    chk("pending_blocks_ready", cfg_ready, 0);
    cfg_div = 8'd3; cfg_valid = 1'b1;
    tick();
    chk("second_offer_blocked", cfg_ready, 0);
    wait_rise();
    measure(h, l);
    chk("change_hi_7", h, 4);
    chk("change_lo_7", l, 3);
    measure(h, l);
    chk("second_hi_3", h, 2);
    chk("second_lo_3", l, 1);
    measure(h, l);
    chk("second_hi_3b", h, 2);
    chk("second_lo_3b", l, 1);

    // en dropped at cnt=1 with R=6: period finishes, then idle.
    do_reset();
    program_idle(8'd6);
    start_run();
    tick();
    en = 1'b0;
    k = 0;
    while (active === 1'b1 && k < 20) begin
      tick(); k++;
    end
    chk("stop_edges_to_idle", k, 5);
    chk("stop_clkout_low", clkout, 0);

    // en returns during STOP: the period keeps its length.
    start_run();
    tick();
    en = 1'b0;
    tick();
    tick();
    en = 1'b1;
    k = 3;
    while (!(rise === 1'b1) && k < 40) begin
      tick(); k++;
    end
    chk("resume_period_len", k, 6);
    measure(h, l);
    chk("resume_hi", h, 3);
    chk("resume_lo", l, 3);

    // Reset pulse mid-high: clkout drops without waiting for clk, ratio back to 2.
    do_reset();
    program_idle(8'd255);
    start_run();
    repeat (10) tick();
    chk("pre_reset_high", clkout, 1);
    #2 nreset = 1'b0;
    #1;
    chk("async_rst_clkout", clkout, 0);
    chk("async_rst_active", active, 0);
    chk("async_rst_ready", cfg_ready, 1);
    en = 1'b0;
    @(negedge clk);
    nreset = 1'b1;
    model_reset();
    tick();
    start_run();
    measure(h, l);
    chk("post_reset_hi", h, 1);
    chk("post_reset_lo", l, 1);

    // Randomized ratio offers and enable toggles against the model.
    do_reset();
    en = 1'b1;
    for (int t = 0; t < 1500; t++) begin
      if (!cfg_valid && $urandom_range(0, 5) == 0) begin
        cfg_valid = 1'b1;
        if ($urandom_range(0, 9) == 0) cfg_div = N'($urandom_range(20, 40));
        else cfg_div = N'($urandom_range(0, 12));
      end
      if ($urandom_range(0, 59) == 0) en = !en;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/asic_clkdiv_prog.md
Name: asic_clkdiv_prog

Overview:
- Programmable integer clock divider built only from positive-edge registers.
- Its registered divided-clock output feeds an inverter cell directly downstream, which produces the complementary clock phase.
- Ratio changes arrive over a valid/ready handshake and are applied only at period boundaries. The output never shows a runt pulse or a glitch.
- Instantiated in clock-generation blocks next to the other asic_* cells.

Parameters:
- N, 8, width of ratio and counter; supported ratios 2..2^N-1.
- PROP, "DEFAULT", implementation property string passed through to library cells.

Ports:
- clk  input  1  source clock.
- nreset  input  1  asynchronous active-low reset.
- en  input  1  run enable; level-sensitive.
- cfg_valid  input  1  new ratio offered.
- cfg_div  input  N  requested divide ratio R.
- cfg_ready  output  1  divider can accept a ratio this cycle.
- clkout  output  1  registered divided clock; drives the downstream inverter.
- rise  output  1  one-clk pulse in the cycle clkout goes 0->1.
- fall  output  1  one-clk pulse in the cycle clkout goes 1->0.
- active  output  1  high while the divider is in RUN or STOP.

Behaviour:
- Interface: one clock, clk. Reset nreset is asynchronous and active-low. Everything else is synchronous to the rising edge of clk.
- Reset values:
  - clkout=0, rise=0, fall=0, active=0, cfg_ready=1.
  - cnt=0, ratio=2, pend_valid=0, state=IDLE.
- Ratio clamp: on capture, cfg_div<2 is clamped to 2. Values up to 2^N-1 are accepted unchanged.
- Handshake:
  - A transfer occurs when cfg_valid && cfg_ready at a clk edge.
  - cfg_ready = !pend_valid. There is one pending slot.
  - In IDLE a transfer loads ratio directly and pend_valid stays 0.
  - In RUN or STOP a transfer loads pend and sets pend_valid.
- Waveform:
  - hi = R - floor(R/2) = ceil(R/2).
  - cnt runs 0..R-1 and wraps to 0.
  - clkout is registered as the next-state decode (cnt_next < hi), so clkout=1 for hi clk cycles and 0 for floor(R/2) cycles.
  - Period is exactly R clk cycles. Odd R gives the extra cycle high.
- Period boundary: the cycle in which cnt==R-1.
  - On this cycle, if pend_valid, then ratio<=pend, pend_valid<=0 and cnt<=0.
  - The next period uses the new ratio, with no shortened high or low phase.
- State machine:
  - IDLE: clkout=0, cnt=0. Go to RUN when en=1. The first rise occurs the cycle after the transition, so latency from en=1 to clkout=1 is 2 clk edges.
  - RUN: counting. If en=0, go to STOP.
  - STOP: keep counting to the period boundary, then go to IDLE with clkout=0. If en returns to 1 before the boundary, go back to RUN with no phase disturbance.
- rise and fall are registered edge detects of clkout's next value. They are coincident with the clkout transition and never asserted together.
- A pending ratio is still applied if a STOP boundary is reached. IDLE then holds the new ratio.
- Simultaneous transfer and boundary in the same cycle:
  - cfg_ready was high, so pend was empty.
  - The boundary applies nothing.
  - The new value becomes pending and is applied at the next boundary.
- Reset mid-period forces all reset values immediately; clkout drops asynchronously.
- cnt width is N. Comparisons are unsigned N-bit. cnt never reaches R.

Decomposition:
- Shared package holds:
  - state enum IDLE/RUN/STOP;
  - constant RATIO_MIN=2;
  - a function computing hi from R.
- Natural sub-module: asic_clkdiv_cnt, the N-bit wrap counter with load and terminal-count output. The FSM, handshake and output registers stay in the top module.

Test Plan:
- Reset then en=1 with R=2 -> clkout toggles every clk edge; the first rise is 2 edges after en; rise and fall alternate each cycle.
- cfg_div=5 in IDLE, then en=1 -> clkout high 3, low 2, period 5; measure over 10 periods.
- R=4 running, offer cfg_div=7 mid-period -> cfg_ready drops for one pending interval. The current 4-cycle period completes, then high 4 / low 3. No period shorter than 4.
- Offer a second ratio while pend_valid=1 -> cfg_ready=0 and the value is not taken. It is accepted after the boundary and applied one period later.
- en=0 at cnt=1 with R=6 -> the period finishes, clkout is 0, active=0 after the boundary. en=1 during STOP -> no phase break.
- cfg_div=0 and cfg_div=1 -> both behave as R=2. cfg_div=255 (N=8) -> high 128, low 127. nreset pulse mid-high -> clkout=0 immediately and state=IDLE.
